// File: rtl/mmio_uart_timer_if.sv
// rtl/mmio_uart_timer_if.sv - core data-port signals seen by the UART/timer peripheral
interface mmio_uart_timer_if;
  logic        we;
  logic [31:0] adr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        sel;

  modport master (output we, adr, wd, input rd, sel);
  modport slave  (input we, adr, wd, output rd, sel);
endinterface

// File: rtl/mmio_uart_timer.sv
// rtl/mmio_uart_timer.sv - memory-mapped TX FIFO, 8N1 transmitter and down-counting timer
module mmio_uart_timer #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  mmio_uart_timer_if.slave bus,
  output logic             tx,
  output logic             irq
);
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam int BCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic           sel, wr, unused_adr;
  logic [2:0]     off;
  logic           push_req, push, pop, full, empty, busy;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  fifo_cnt;
  state_t         state_q, state_d;
  logic [BCW-1:0] bit_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           bit_done, tx_d;
  logic [31:0]    load_q, count_q, count_d;
  logic [2:0]     ctrl_q, ctrl_d;
  logic           tirq_q, tirq_d, ovf_q, ovf_d, expire;
  logic [31:0]    status, rd_data;

  assign sel        = bus.adr[31:5] == BASE_ADDR[31:5];
  assign off        = bus.adr[4:2];
  assign wr         = bus.we & sel;
  assign unused_adr = ^bus.adr[1:0];

  assign full     = fifo_cnt == CW'(FIFO_DEPTH);
  assign empty    = fifo_cnt == '0;
  assign push_req = wr && off == 3'd0;
  assign push     = push_req && !full;
  assign pop      = state_q == IDLE && !empty;
  assign busy     = state_q != IDLE;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wd[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: ;
      endcase
    end
  end

  assign bit_done = bit_cnt == BCW'(CLKS_PER_BIT - 1);

  always_comb begin
    state_d = state_q;
    tx_d    = 1'b1;
    case (state_q)
      IDLE:  if (!empty) state_d = START;
      START: begin
        tx_d = 1'b0;
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        tx_d = shreg[0];
        if (bit_done && bit_idx == 3'd7) state_d = STOP;
      end
      STOP:    if (bit_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // tx is registered so the line is glitch-free; it trails the state by one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      state_q <= state_d;
      tx      <= tx_d;
      if (state_q == IDLE) begin
        bit_cnt <= '0;
        bit_idx <= '0;
        if (pop) shreg <= mem[rd_ptr];
      end else if (bit_done) begin
        bit_cnt <= '0;
        if (state_q == DATA) begin
          shreg   <= shreg >> 1;
          bit_idx <= bit_idx + 3'd1;
        end
      end else begin
        bit_cnt <= bit_cnt + BCW'(1);
      end
    end
  end

  assign expire = ctrl_q[0] && count_q == '0;

  // Ordering makes bus writes win over expiry for COUNT, and sets win over W1C clears
  always_comb begin
    count_d = count_q;
    ctrl_d  = ctrl_q;
    tirq_d  = tirq_q;
    ovf_d   = ovf_q;
    if (expire) begin
      count_d = ctrl_q[1] ? load_q : '0;
      if (!ctrl_q[1]) ctrl_d[0] = 1'b0;
    end else if (ctrl_q[0]) begin
      count_d = count_q - 32'd1;
    end
    if (wr && off == 3'd2) count_d = bus.wd;
    if (wr && off == 3'd3) ctrl_d = bus.wd[2:0];
    if (wr && off == 3'd1) begin
      if (bus.wd[0]) tirq_d = 1'b0;
      if (bus.wd[4]) ovf_d = 1'b0;
    end
    if (expire) tirq_d = 1'b1;
    if (push_req && full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_q  <= '0;
      count_q <= '0;
      ctrl_q  <= '0;
      tirq_q  <= 1'b0;
      ovf_q   <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (wr && off == 3'd2) load_q <= bus.wd;
      count_q <= count_d;
      ctrl_q  <= ctrl_d;
      tirq_q  <= tirq_d;
      ovf_q   <= ovf_d;
      irq     <= tirq_d & ctrl_d[2];
    end
  end

  always_comb begin
    status            = '0;
    status[0]         = tirq_q;
    status[1]         = empty;
    status[2]         = full;
    status[3]         = busy;
    status[4]         = ovf_q;
    status[8 +: CW]   = fifo_cnt;
    rd_data           = '0;
    if (sel) begin
      case (off)
        3'd1:    rd_data = status;
        3'd2:    rd_data = load_q;
        3'd3:    rd_data = {29'd0, ctrl_q};
        3'd4:    rd_data = count_q;
        default: rd_data = '0;
      endcase
    end
  end

  assign bus.rd  = rd_data;
  assign bus.sel = sel;
endmodule

// File: tb/tb_mmio_uart_timer.sv
// tb/tb_mmio_uart_timer.sv - scoreboard bench for the UART/timer peripheral
module tb_mmio_uart_timer;
  localparam int          CPB    = 4;
  localparam logic [31:0] TXDATA = 32'h100;
  localparam logic [31:0] STATUS = 32'h104;
  localparam logic [31:0] LOAD   = 32'h108;
  localparam logic [31:0] CTRL   = 32'h10C;
  localparam logic [31:0] COUNT  = 32'h110;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx, irq;
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] exp_q[$];
  bit   mon_en = 1'b1;

  mmio_uart_timer_if bus();

  mmio_uart_timer #(.BASE_ADDR(32'h100), .FIFO_DEPTH(4), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .bus(bus), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.we  = 1'b1;
    bus.adr = a;
    bus.wd  = d;
    tick();
    bus.we  = 1'b0;
    bus.adr = 32'h0;
    bus.wd  = 32'h0;
  endtask

  task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.adr = a;
    #1;
    check(tag, bus.rd, exp);
  endtask

  task automatic drain();
    int i = 0;
    bus.adr = STATUS;
    #1;
    while ((exp_q.size() != 0 || bus.rd[3]) && i < 2000) begin
      tick();
      i++;
    end
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    check_reg("drain_idle", STATUS, 32'h2);
  endtask

  // Serial receiver: samples mid-bit on negedges and scores against expected bytes
  initial begin : rx_mon
    logic [7:0] b;
    logic       stop;
    forever begin
      @(negedge clk);
      if (mon_en && !reset && tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        check("rx_start", 32'(tx), 32'd0);
        for (int j = 0; j < 8; j++) begin
          repeat (CPB) @(negedge clk);
          b[j] = tx;
        end
        repeat (CPB) @(negedge clk);
        stop = tx;
        check("rx_stop", 32'(stop), 32'd1);
        check("rx_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("rx_byte", 32'(b), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [9:0] frame;
    bus.we  = 1'b0;
    bus.adr = 32'h0;
    bus.wd  = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check_reg("reset_status", STATUS, 32'h2);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_irq", 32'(irq), 32'd0);
    check("sel_in", 32'(bus.sel), 32'd1);
    check_reg("unmapped_rd", 32'h114, 32'h0);
    check_reg("txdata_rd", TXDATA, 32'h0);
    check_reg("outside_rd", 32'h0FC, 32'h0);
    check("outside_sel", 32'(bus.sel), 32'd0);

    // Single byte, exact bit timing
    exp_q.push_back(8'h55);
    bus_write(TXDATA, 32'h55);
    check("tx_pre_pop", 32'(tx), 32'd1);
    check_reg("stat_queued", STATUS, 32'h100);
    tick();
    check("tx_at_pop", 32'(tx), 32'd1);
    check_reg("stat_popped", STATUS, 32'h00A);
    frame = {1'b1, 8'h55, 1'b0};
    for (int m = 2; m <= 41; m++) begin
      tick();
      check("tx_bit", 32'(tx), 32'(frame[(m - 2) / CPB]));
      check_reg("stat_frame", STATUS, (m <= 40) ? 32'h00A : 32'h002);
    end

    // Burst, overflow, W1C of ovf
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'(8'h11 + i));
      bus_write(TXDATA, 32'h11 + 32'(i));
    end
    bus_write(TXDATA, 32'h16);
    check_reg("stat_ovf", STATUS, 32'h41C);
    bus_write(STATUS, 32'h10);
    check_reg("stat_ovf_clr", STATUS, 32'h40C);
    drain();

    // Autoreload timer
    bus_write(LOAD, 32'd3);
    bus_write(CTRL, 32'h7);
    for (int k = 0; k < 5; k++) begin
      check_reg("count_ar", COUNT, (k < 4) ? 32'(3 - k) : 32'd3);
      check_reg("tirq_ar", STATUS, (k == 4) ? 32'h3 : 32'h2);
      check("irq_ar", 32'(irq), (k == 4) ? 32'd1 : 32'd0);
      if (k < 4) tick();
    end
    bus_write(STATUS, 32'h1);
    check_reg("tirq_clr", STATUS, 32'h2);
    check("irq_clr", 32'(irq), 32'd0);
    tick();
    tick();
    check_reg("tirq_pre", STATUS, 32'h2);
    tick();
    check_reg("tirq_again", STATUS, 32'h3);
    check_reg("count_reload", COUNT, 32'd3);
    check("irq_again", 32'(irq), 32'd1);
    bus_write(CTRL, 32'h0);
    tick();
    check_reg("count_frozen", COUNT, 32'd2);
    check_reg("ctrl_off", CTRL, 32'h0);

    // One-shot
    bus_write(STATUS, 32'h1);
    bus_write(LOAD, 32'd2);
    bus_write(CTRL, 32'h5);
    check_reg("os_count2", COUNT, 32'd2);
    tick();
    check_reg("os_count1", COUNT, 32'd1);
    tick();
    check_reg("os_pre", STATUS, 32'h2);
    tick();
    check_reg("os_tirq", STATUS, 32'h3);
    check("os_irq", 32'(irq), 32'd1);
    check_reg("os_ctrl", CTRL, 32'h4);
    check_reg("os_count0", COUNT, 32'd0);
    tick();
    check_reg("os_hold", COUNT, 32'd0);

    // W1C colliding with a fresh expiry
    bus_write(STATUS, 32'h1);
    check_reg("col_clr", STATUS, 32'h2);
    bus_write(LOAD, 32'd1);
    bus_write(CTRL, 32'h5);
    tick();
    bus_write(STATUS, 32'h1);
    check_reg("col_set_wins", STATUS, 32'h3);
    check_reg("col_ctrl", CTRL, 32'h4);

    // LOAD write colliding with expiry
    bus_write(LOAD, 32'd1);
    bus_write(CTRL, 32'h5);
    tick();
    bus_write(LOAD, 32'd9);
    check_reg("ldw_count", COUNT, 32'd9);
    check_reg("ldw_ctrl", CTRL, 32'h4);

    // Reset in the middle of a frame
    bus_write(LOAD, 32'd50);
    bus_write(CTRL, 32'h5);
    check("pre_rst_irq", 32'(irq), 32'd1);
    mon_en = 1'b0;
    bus_write(TXDATA, 32'hA5);
    bus_write(TXDATA, 32'h3C);
    for (int i = 0; i < 50 && tx !== 1'b0; i++) tick();
    check("rst_tx_low", 32'(tx), 32'd0);
    repeat (6) tick();
    #1 reset = 1'b1;
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check_reg("rst_status", STATUS, 32'h2);
    check_reg("rst_count", COUNT, 32'd0);
    check_reg("rst_ctrl", CTRL, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("post_rst_tx", 32'(tx), 32'd1);
    end
    check_reg("post_rst_status", STATUS, 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
